// File: rtl/pipe_result_collector.sv
// Collects F results from the fixed-latency pipe_ex datapath into a credit-gated FIFO.
// Optional PIPE_RESULT_COUNT_EN adds a 16-bit count of results handed to the consumer.
module pipe_result_collector #(
    parameter int N     = 10,
    parameter int LAT   = 3,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [N-1:0]  pipe_f,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level
`ifdef PIPE_RESULT_COUNT_EN
    ,
    output logic [15:0]   result_count
`endif
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [LAT-1:0] vsr;
    logic [AW:0]    total;
    logic [AW:0]    count;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [N-1:0]   mem [DEPTH];
    logic           fire;
    logic           pop;
    logic           wr;

    assign fire        = issue_valid & issue_ready;
    assign pop         = out_valid & out_ready;
    assign wr          = vsr[LAT-1];
    // Ready depends on registered credit only, so out_ready never reaches it combinationally
    assign issue_ready = (total != FULL);
    assign out_valid   = (count != '0);
    assign level       = count;
    assign out_data    = mem[rd_ptr];

    // Shadow of pipe_ex: a 1 at the top means pipe_f currently holds a fired set's F
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr <= '0;
        end else begin
            vsr[0] <= fire;
            for (int i = 1; i < LAT; i++) vsr[i] <= vsr[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total <= '0;
        end else begin
            case ({fire, pop})
                2'b10:   total <= total + 1'b1;
                2'b01:   total <= total - 1'b1;
                default: total <= total;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= pipe_f;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef PIPE_RESULT_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   result_count <= '0;
        else if (pop) result_count <= result_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector with a pipe_ex stand-in and a queue-based reference model.
module tb_pipe_result_collector;
    localparam int N = 10, LAT = 3, DEPTH = 4, AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          issue_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  a = '0, b = '0, c = '0, d = '0;
    logic [N-1:0]  s1, s2, pipe_f;
    logic          issue_ready, out_valid;
    logic [N-1:0]  out_data;
    logic [AW:0]   level;
`ifdef PIPE_RESULT_COUNT_EN
    logic [15:0]   result_count;
`endif

    int vecs = 0;
    int errs = 0;
    bit run = 1'b0;

    pipe_result_collector #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .pipe_f(pipe_f),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level)
`ifdef PIPE_RESULT_COUNT_EN
        , .result_count(result_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] fcalc(input logic [N-1:0] fa, fb, fc, fd);
        int r;
        r = ((int'(fa) + int'(fb)) + (int'(fc) - int'(fd))) * int'(fd);
        return r[N-1:0];
    endfunction

    // pipe_ex stand-in: operands captured at edge k, F on pipe_f after edge k+2; never reset
    always @(posedge clk) begin
        s1     <= fcalc(a, b, c, d);
        s2     <= s1;
        pipe_f <= s2;
    end

    // Reference: results in flight with their due edge, stored results, credit = sum of both
    typedef struct { logic [N-1:0] f; int due; } fl_t;
    fl_t          infl[$];
    logic [N-1:0] fifo[$];
    fl_t          tmp;
    int           edge_n = 0;
    int           pops_m = 0;
    bit           m_rdy, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl.delete();
            fifo.delete();
            pops_m = 0;
            edge_n = 0;
        end else begin
            m_rdy = (infl.size() + fifo.size()) != DEPTH;
            m_pop = (fifo.size() != 0) && out_ready;
            if (m_pop) begin
                void'(fifo.pop_front());
                pops_m++;
            end
            while (infl.size() != 0 && infl[0].due == edge_n) begin
                tmp = infl.pop_front();
                fifo.push_back(tmp.f);
            end
            if (issue_valid && m_rdy) begin
                tmp.f   = fcalc(a, b, c, d);
                tmp.due = edge_n + LAT;
                infl.push_back(tmp);
            end
            edge_n++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("model issue_ready", issue_ready, ((infl.size() + fifo.size()) != DEPTH));
            chk("model out_valid", out_valid, (fifo.size() != 0));
            chk("model level", level, fifo.size());
            if (fifo.size() != 0) chk("model out_data", out_data, fifo[0]);
`ifdef PIPE_RESULT_COUNT_EN
            chk("model result_count", result_count, pops_m % 65536);
`endif
        end
    end

    task automatic cyc(input bit iv, input int ra, rb, rc, rd, input bit ordy);
        issue_valid = iv;
        a = N'(ra); b = N'(rb); c = N'(rc); d = N'(rd);
        out_ready = ordy;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 0, ordy);
    endtask

    initial begin
        // 1: async reset asserted mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("rst issue_ready", issue_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst level", level, 0);
        chk("rst out_data", out_data, 0);
`ifdef PIPE_RESULT_COUNT_EN
        chk("rst result_count", result_count, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run = 1'b1;

        // 2: single fire, result after edge k+3, popped at k+4
        cyc(1'b1, 5, 6, 7, 8, 1'b1);
        idle(2, 1'b1);
        chk("t2 valid early", out_valid, 0);
        idle(1, 1'b1);
        chk("t2 valid", out_valid, 1);
        chk("t2 data", out_data, 80);
        chk("t2 level", level, 1);
        idle(1, 1'b1);
        chk("t2 level after pop", level, 0);
`ifdef PIPE_RESULT_COUNT_EN
        chk("t2 result_count", result_count, 1);
`endif

        // 3: three back-to-back fires, drained in order
        cyc(1'b1, 5, 6, 7, 8, 1'b0);
        cyc(1'b1, 9, 10, 11, 12, 1'b0);
        cyc(1'b1, 10, 6, 7, 8, 1'b0);
        idle(3, 1'b0);
        chk("t3 level", level, 3);
        issue_valid = 1'b0;
        out_ready = 1'b1;
        #1 chk("t3 data0", out_data, 80);
        @(posedge clk); #1 chk("t3 data1", out_data, 216);
        @(posedge clk); #1 chk("t3 data2", out_data, 120);
        @(posedge clk); #1 chk("t3 drained", level, 0);
`ifdef PIPE_RESULT_COUNT_EN
        chk("t3 result_count", result_count, 4);
`endif

        // 4: credit exhaustion, fifth issue held
        for (int i = 0; i < 4; i++) cyc(1'b1, i, 1, 2, 3, 1'b0);
        chk("t4 ready after 4", issue_ready, 0);
        cyc(1'b1, 2, 2, 2, 2, 1'b0);
        idle(3, 1'b0);
        chk("t4 level full", level, 4);
        chk("t4 ready full", issue_ready, 0);
        out_ready = 1'b1;
        #1 chk("t4 ready same cycle", issue_ready, 0);
        @(posedge clk); #1;
        chk("t4 ready next cycle", issue_ready, 1);
        chk("t4 level", level, 3);

        // 5: fire and pop on the same edge at total=3 while a write also lands
        cyc(1'b0, 0, 0, 0, 0, 1'b1);
        chk("t5 level pre", level, 2);
        cyc(1'b1, 3, 4, 5, 6, 1'b0);
        idle(2, 1'b0);
        issue_valid = 1'b1;
        a = 7; b = 7; c = 7; d = 7;
        out_ready = 1'b1;
        #1;
        chk("t5 level before", level, 2);
        chk("t5 ready before", issue_ready, 1);
        @(posedge clk); #1;
        chk("t5 level after", level, 2);
        chk("t5 ready after", issue_ready, 1);
        idle(8, 1'b1);
        chk("t5 drained", level, 0);

        // 6: reset discards in-flight work
        cyc(1'b1, 5, 6, 7, 8, 1'b0);
        cyc(1'b1, 10, 6, 7, 8, 1'b0);
        issue_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("t6 rst level", level, 0);
        chk("t6 rst ready", issue_ready, 1);
        rst_n = 1'b1;
        idle(5, 1'b0);
        chk("t6 no stale valid", out_valid, 0);
`ifdef PIPE_RESULT_COUNT_EN
        chk("t6 result_count", result_count, 0);
`endif
        cyc(1'b1, 9, 10, 11, 12, 1'b0);
        idle(3, 1'b0);
        chk("t6 valid", out_valid, 1);
        chk("t6 data", out_data, 216);
        idle(1, 1'b1);
        chk("t6 level after pop", level, 0);

        idle(3, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
